// File: rtl/card_pkg.sv
// Shared card-code definitions for the shoe, game FSM and 7-segment display decoder.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_NONE = 4'd0;
    localparam card_t CARD_ACE  = 4'd1;
    localparam card_t CARD_KING = 4'd13;
    localparam int    NUM_RANKS = 13;

    typedef enum logic {
        S_IDLE,
        S_SEARCH
    } shoe_state_t;

    // Rank successor on the 1..13 ring; King wraps back to Ace.
    function automatic card_t next_rank(input card_t c);
        return (c == CARD_KING) ? CARD_ACE : c + 4'd1;
    endfunction

endpackage

// File: rtl/card_shoe_rank_spinner.sv
// Free-running Ace..King counter used as the starting point of each draw.
// It keeps turning through shuffles so successive shoes see different draw orders.
module rank_spinner
    import card_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    output card_t spin
);

    card_t spin_q;
    card_t spin_d;

    // Next spinner value: step around the 1..13 ring.
    always_comb begin
        spin_d = next_rank(spin_q);
    end

    // Spinner register; reset parks it on Ace.
    always_ff @(posedge clock) begin
        if (reset) begin
            spin_q <= CARD_ACE;
        end else begin
            spin_q <= spin_d;
        end
    end

    assign spin = spin_q;

endmodule

// File: rtl/card_shoe.sv
// Card shoe: tracks remaining cards per rank and deals one card per request.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | waiting for deal_req; a request is taken only if the shoe has cards
//  S_SEARCH | walking ranks from the spinner value until a non-exhausted one is found
//
// Because a request is only accepted while cards_left is non-zero, the search
// always finds a rank within one lap of the ring (at most 13 edges).
module card_shoe
    import card_pkg::*;
#(
    parameter int NUM_DECKS = 1,
    localparam int RANK_W   = $clog2(4 * NUM_DECKS + 1),
    localparam int LEFT_W   = $clog2(52 * NUM_DECKS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              shuffle,
    input  logic              deal_req,
    output logic [3:0]        new_card,
    output logic              card_valid,
    output logic              busy,
    output logic              shoe_empty,
    output logic [LEFT_W-1:0] cards_left
);

    localparam logic [RANK_W-1:0] RANK_FULL = RANK_W'(4 * NUM_DECKS);
    localparam logic [LEFT_W-1:0] LEFT_FULL = LEFT_W'(52 * NUM_DECKS);

    card_t spin;

    rank_spinner u_spinner (
        .clock (clock),
        .reset (reset),
        .spin  (spin)
    );

    shoe_state_t       state_q,      state_d;
    card_t             cand_q,       cand_d;
    logic [RANK_W-1:0] count_q [1:NUM_RANKS];
    logic [RANK_W-1:0] count_d [1:NUM_RANKS];
    logic [LEFT_W-1:0] left_q,       left_d;
    card_t             new_card_q,   new_card_d;
    logic              card_valid_q, card_valid_d;
    logic              busy_q,       busy_d;
    logic              cand_avail;

    assign shoe_empty = (left_q == '0);

    // Next-state logic: accept/search/deal, with shuffle overriding the FSM.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        left_d       = left_q;
        new_card_d   = new_card_q;
        card_valid_d = 1'b0;
        cand_avail   = 1'b0;
        for (int r = 1; r <= NUM_RANKS; r++) begin
            count_d[r] = count_q[r];
            if (cand_q == card_t'(r) && count_q[r] != '0) begin
                cand_avail = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (deal_req && !shoe_empty) begin
                    cand_d  = spin;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cand_avail) begin
                    for (int r = 1; r <= NUM_RANKS; r++) begin
                        if (cand_q == card_t'(r)) begin
                            count_d[r] = count_q[r] - RANK_W'(1);
                        end
                    end
                    left_d       = left_q - LEFT_W'(1);
                    new_card_d   = cand_q;
                    card_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cand_d = next_rank(cand_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Refill wins over any deal in flight; no pulse is produced for an aborted search.
        if (shuffle) begin
            state_d      = S_IDLE;
            cand_d       = CARD_ACE;
            left_d       = LEFT_FULL;
            new_card_d   = CARD_NONE;
            card_valid_d = 1'b0;
            for (int r = 1; r <= NUM_RANKS; r++) begin
                count_d[r] = RANK_FULL;
            end
        end

        busy_d = (state_d == S_SEARCH);
    end

    // Shoe state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cand_q       <= CARD_ACE;
            left_q       <= LEFT_FULL;
            new_card_q   <= CARD_NONE;
            card_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int r = 1; r <= NUM_RANKS; r++) begin
                count_q[r] <= RANK_FULL;
            end
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            left_q       <= left_d;
            new_card_q   <= new_card_d;
            card_valid_q <= card_valid_d;
            busy_q       <= busy_d;
            for (int r = 1; r <= NUM_RANKS; r++) begin
                count_q[r] <= count_d[r];
            end
        end
    end

    assign new_card   = new_card_q;
    assign card_valid = card_valid_q;
    assign busy       = busy_q;
    assign cards_left = left_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe with a single-deck shoe.
module tb_card_shoe;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       shuffle = 1'b0;
    logic       deal_req = 1'b0;
    logic [3:0] new_card;
    logic       card_valid;
    logic       busy;
    logic       shoe_empty;
    logic [5:0] cards_left;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] tb_spin = 4'd1;

    card_shoe #(.NUM_DECKS(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .shuffle    (shuffle),
        .deal_req   (deal_req),
        .new_card   (new_card),
        .card_valid (card_valid),
        .busy       (busy),
        .shoe_empty (shoe_empty),
        .cards_left (cards_left)
    );

    always #5 clock = ~clock;

    // Reference spinner: resets to 1, otherwise steps 1..13 every edge.
    always @(posedge clock) begin
        tb_spin <= reset ? 4'd1 : ((tb_spin == 4'd13) ? 4'd1 : tb_spin + 4'd1);
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; shuffle = 1'b0; deal_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Raise deal_req for the single edge at which the spinner shows v, then wait for the card.
    task automatic deal_at(input int v, output logic [3:0] card, output int lat, output logic busy_seen);
        int n;
        n = 0; card = 4'd0; lat = -1; busy_seen = 1'b0;
        while (int'(tb_spin) != v && n < 20) begin
            @(negedge clock);
            n++;
        end
        deal_req = 1'b1;
        @(negedge clock);
        deal_req = 1'b0;
        busy_seen = busy;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (card_valid) begin
                lat = i;
                card = new_card;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (new_card !== 4'd0) begin miscompares++; $display("FAIL reset_new_card got %0d want 0", new_card); end
        vectors++; if (card_valid !== 1'b0) begin miscompares++; $display("FAIL reset_card_valid got %b want 0", card_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (cards_left !== 6'd52) begin miscompares++; $display("FAIL reset_cards_left got %0d want 52", cards_left); end
        vectors++; if (shoe_empty !== 1'b0) begin miscompares++; $display("FAIL reset_shoe_empty got %b want 0", shoe_empty); end
        vectors++; if (dut.u_spinner.spin_q !== 4'd1) begin miscompares++; $display("FAIL reset_spin got %0d want 1", dut.u_spinner.spin_q); end
    endtask

    task automatic test_single_deal();
        logic [3:0] card; int lat; logic bs;
        do_reset();
        deal_at(5, card, lat, bs);
        vectors++; if (bs !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b want 1", bs); end
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL single_latency got %0d want 1", lat); end
        vectors++; if (card !== 4'd5) begin miscompares++; $display("FAIL single_card got %0d want 5", card); end
        vectors++; if (cards_left !== 6'd51) begin miscompares++; $display("FAIL single_cards_left got %0d want 51", cards_left); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after got %b want 0", busy); end
        @(negedge clock);
        vectors++; if (card_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse_width got %b want 0", card_valid); end
        vectors++; if (new_card !== 4'd5) begin miscompares++; $display("FAIL single_card_hold got %0d want 5", new_card); end
    endtask

    task automatic test_skip_exhausted();
        logic [3:0] card; int lat; logic bs;
        for (int k = 0; k < 4; k++) begin
            deal_at(7, card, lat, bs);
            vectors++; if (card !== 4'd7 || lat != 1) begin miscompares++; $display("FAIL skip_seven_%0d got card %0d lat %0d want 7 lat 1", k, card, lat); end
        end
        deal_at(7, card, lat, bs);
        vectors++; if (card !== 4'd8) begin miscompares++; $display("FAIL skip_card got %0d want 8", card); end
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL skip_latency got %0d want 2", lat); end
        vectors++; if (dut.count_q[7] !== 3'd0) begin miscompares++; $display("FAIL skip_rank7_count got %0d want 0", dut.count_q[7]); end
        vectors++; if (cards_left !== 6'd46) begin miscompares++; $display("FAIL skip_cards_left got %0d want 46", cards_left); end
    endtask

    task automatic test_max_latency();
        logic [3:0] card; int lat; logic bs;
        do_reset();
        for (int r = 1; r <= 12; r++) begin
            for (int k = 0; k < 4; k++) begin
                deal_at(r, card, lat, bs);
                vectors++; if (int'(card) != r) begin miscompares++; $display("FAIL exhaust_rank_%0d got %0d want %0d", r, card, r); end
            end
        end
        vectors++; if (cards_left !== 6'd4) begin miscompares++; $display("FAIL exhaust_cards_left got %0d want 4", cards_left); end
        deal_at(1, card, lat, bs);
        vectors++; if (card !== 4'd13) begin miscompares++; $display("FAIL maxlat_card got %0d want 13", card); end
        vectors++; if (lat != 13) begin miscompares++; $display("FAIL maxlat_latency got %0d want 13", lat); end
        vectors++; if (cards_left !== 6'd3) begin miscompares++; $display("FAIL maxlat_cards_left got %0d want 3", cards_left); end
    endtask

    task automatic test_back_to_back();
        int hist [14];
        int pulses, t1, t2, cyc, bad, hist_bad, late;
        logic [3:0] c1, c2, c1_plus2;
        for (int i = 0; i < 14; i++) hist[i] = 0;
        pulses = 0; t1 = 0; t2 = 0; bad = 0; late = 0; c1 = 4'd0; c2 = 4'd0;
        do_reset();
        deal_req = 1'b1;
        for (cyc = 1; cyc <= 1500; cyc++) begin
            @(negedge clock);
            if (card_valid) begin
                pulses++;
                if (new_card == 4'd0 || new_card > 4'd13) bad++;
                else hist[new_card]++;
                if (pulses == 1) begin t1 = cyc; c1 = new_card; end
                if (pulses == 2) begin t2 = cyc; c2 = new_card; end
                if (pulses == 52) break;
            end
        end
        hist_bad = 0;
        for (int r = 1; r <= 13; r++) if (hist[r] != 4) hist_bad++;
        c1_plus2 = (c1 >= 4'd12) ? c1 - 4'd11 : c1 + 4'd2;
        vectors++; if (pulses != 52) begin miscompares++; $display("FAIL hold_pulses got %0d want 52", pulses); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_bad_codes got %0d want 0", bad); end
        vectors++; if (hist_bad != 0) begin miscompares++; $display("FAIL hold_rank_histogram got %0d ranks off want 0", hist_bad); end
        vectors++; if (t2 - t1 != 2) begin miscompares++; $display("FAIL hold_gap got %0d want 2", t2 - t1); end
        vectors++; if (c2 !== c1_plus2) begin miscompares++; $display("FAIL hold_second_card got %0d want %0d", c2, c1_plus2); end
        vectors++; if (cards_left !== 6'd0) begin miscompares++; $display("FAIL hold_cards_left got %0d want 0", cards_left); end
        vectors++; if (shoe_empty !== 1'b1) begin miscompares++; $display("FAIL hold_shoe_empty got %b want 1", shoe_empty); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (card_valid || busy) late++;
        end
        deal_req = 1'b0;
        vectors++; if (late != 0) begin miscompares++; $display("FAIL empty_requests got %0d active cycles want 0", late); end
    endtask

    task automatic test_shuffle();
        logic [3:0] card; int lat; logic bs;
        // Shuffle while a search is pending.
        do_reset();
        deal_at(3, card, lat, bs);
        vectors++; if (card !== 4'd3 || cards_left !== 6'd51) begin miscompares++; $display("FAIL shuf_setup got card %0d left %0d want 3 left 51", card, cards_left); end
        deal_req = 1'b1;
        @(negedge clock);
        deal_req = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL shuf_busy_before got %b want 1", busy); end
        shuffle = 1'b1;
        @(negedge clock);
        shuffle = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL shuf_search_busy got %b want 0", busy); end
        vectors++; if (card_valid !== 1'b0) begin miscompares++; $display("FAIL shuf_search_valid got %b want 0", card_valid); end
        vectors++; if (new_card !== 4'd0) begin miscompares++; $display("FAIL shuf_search_card got %0d want 0", new_card); end
        vectors++; if (cards_left !== 6'd52) begin miscompares++; $display("FAIL shuf_search_left got %0d want 52", cards_left); end
        vectors++; if (dut.u_spinner.spin_q !== tb_spin) begin miscompares++; $display("FAIL shuf_spin_runs got %0d want %0d", dut.u_spinner.spin_q, tb_spin); end
        @(negedge clock);
        vectors++; if (card_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL shuf_search_late got valid %b busy %b want 0 0", card_valid, busy); end
        // Shuffle together with a fresh request in IDLE.
        deal_at(4, card, lat, bs);
        deal_req = 1'b1; shuffle = 1'b1;
        @(negedge clock);
        deal_req = 1'b0; shuffle = 1'b0;
        vectors++; if (busy !== 1'b0 || card_valid !== 1'b0) begin miscompares++; $display("FAIL shuf_req_flags got busy %b valid %b want 0 0", busy, card_valid); end
        vectors++; if (cards_left !== 6'd52 || new_card !== 4'd0) begin miscompares++; $display("FAIL shuf_req_state got left %0d card %0d want 52 0", cards_left, new_card); end
        @(negedge clock);
        vectors++; if (busy !== 1'b0 || card_valid !== 1'b0) begin miscompares++; $display("FAIL shuf_req_late got busy %b valid %b want 0 0", busy, card_valid); end
        // Reset together with shuffle behaves as plain reset.
        deal_at(6, card, lat, bs);
        @(negedge clock);
        reset = 1'b1; shuffle = 1'b1; deal_req = 1'b1;
        @(negedge clock);
        reset = 1'b0; shuffle = 1'b0; deal_req = 1'b0;
        vectors++; if (dut.u_spinner.spin_q !== 4'd1) begin miscompares++; $display("FAIL rstshuf_spin got %0d want 1", dut.u_spinner.spin_q); end
        vectors++; if (new_card !== 4'd0 || card_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstshuf_outputs got card %0d valid %b busy %b want 0 0 0", new_card, card_valid, busy); end
        vectors++; if (cards_left !== 6'd52 || shoe_empty !== 1'b0) begin miscompares++; $display("FAIL rstshuf_left got %0d empty %b want 52 0", cards_left, shoe_empty); end
    endtask

    initial begin
        test_reset();
        test_single_deal();
        test_skip_exhausted();
        test_max_latency();
        test_back_to_back();
        test_shuffle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
